// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The 2-flop synchronised RXD line is sampled at mid-bit using a runtime-programmable
// bit period. One received byte is held for the register file, along with a valid level,
// a sticky overrun flag and a one-cycle framing-error pulse.
module uart_rx #(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_FREQ  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_bit_period_i,
    input  logic [15:0] bit_period_i,
    input  logic        uart_rxd,
    input  logic        rd_i,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_overrun,
    output logic        rx_frame_err,
    output logic        rx_busy
);

    localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'((CLK_FREQ / BAUD_RATE) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic        sync1_r;
    logic        sync2_r;
    logic        rxd_s;
    logic [15:0] bit_period_r;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] counter_r;
    logic [15:0] counter_next_s;
    logic [2:0]  bit_index_r;
    logic [2:0]  bit_index_next_s;
    logic [7:0]  shreg_r;
    logic [7:0]  shreg_next_s;
    logic        sample_s;

    logic [7:0]  rx_data_r;
    logic [7:0]  data_next_s;
    logic        rx_valid_r;
    logic        valid_next_s;
    logic        rx_overrun_r;
    logic        overrun_next_s;
    logic        rx_frame_err_r;
    logic        frame_err_next_s;
    logic        rx_busy_r;

    assign rxd_s        = sync2_r;
    assign sample_s     = (counter_r == 16'd0);
    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_overrun   = rx_overrun_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_busy      = rx_busy_r;

    // Two-flop synchroniser; the chain idles high like the line itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= uart_rxd;
            sync2_r <= sync1_r;
        end
    end

    // Bit-period register; a new value is only picked up at the next counter reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_period_r <= DEFAULT_BIT_PERIOD;
        end else if (wr_bit_period_i) begin
            bit_period_r <= bit_period_i;
        end else begin
            bit_period_r <= bit_period_r;
        end
    end

    // Next-state and datapath decode: every non-IDLE state acts only when the counter hits zero.
    always_comb begin
        state_next_s     = state_r;
        counter_next_s   = counter_r;
        bit_index_next_s = bit_index_r;
        shreg_next_s     = shreg_r;
        data_next_s      = rx_data_r;
        valid_next_s     = rx_valid_r;
        overrun_next_s   = rx_overrun_r;
        frame_err_next_s = 1'b0;

        if (rd_i) begin
            valid_next_s   = 1'b0;
            overrun_next_s = 1'b0;
        end else begin
            valid_next_s   = rx_valid_r;
            overrun_next_s = rx_overrun_r;
        end

        if ((state_r != IDLE) && !sample_s) begin
            counter_next_s = counter_r - 16'd1;
        end else begin
            counter_next_s = counter_r;
        end

        case (state_r)
            IDLE: begin
                if (!rxd_s) begin
                    counter_next_s   = {1'b0, bit_period_r[15:1]};
                    bit_index_next_s = 3'd0;
                    state_next_s     = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (sample_s) begin
                    if (rxd_s) begin
                        state_next_s = IDLE;
                    end else begin
                        counter_next_s = bit_period_r;
                        state_next_s   = DATA;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (sample_s) begin
                    shreg_next_s     = {rxd_s, shreg_r[7:1]};
                    bit_index_next_s = bit_index_r + 3'd1;
                    counter_next_s   = bit_period_r;
                    if (bit_index_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (sample_s) begin
                    state_next_s = IDLE;
                    if (rxd_s) begin
                        data_next_s  = shreg_r;
                        valid_next_s = 1'b1;
                        if (rx_valid_r && !rd_i) begin
                            overrun_next_s = 1'b1;
                        end else begin
                            overrun_next_s = rd_i ? 1'b0 : rx_overrun_r;
                        end
                    end else begin
                        frame_err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            counter_r      <= 16'd0;
            bit_index_r    <= 3'd0;
            shreg_r        <= 8'd0;
            rx_data_r      <= 8'd0;
            rx_valid_r     <= 1'b0;
            rx_overrun_r   <= 1'b0;
            rx_frame_err_r <= 1'b0;
            rx_busy_r      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            counter_r      <= counter_next_s;
            bit_index_r    <= bit_index_next_s;
            shreg_r        <= shreg_next_s;
            rx_data_r      <= data_next_s;
            rx_valid_r     <= valid_next_s;
            rx_overrun_r   <= overrun_next_s;
            rx_frame_err_r <= frame_err_next_s;
            rx_busy_r      <= (state_next_s != IDLE);
        end
    end

endmodule
